// File: rtl/wr_ddr_burst_arbiter_if.sv
// rtl/wr_ddr_burst_arbiter_if.sv - AXI4 write-channel bundle between the burst arbiter and the DDR controller
//
// Purpose: groups the AW, W and B channel signals of a single-ID AXI4 write master.
// Ports (signals):
//   awaddr/awlen/awvalid/awready : write address channel
//   wdata/wvalid/wlast/wready    : write data channel
//   bvalid/bresp/bready          : write response channel
// Modports: master (arbiter side), slave (DDR controller side).

interface wr_ddr_burst_arbiter_if #(
    parameter int ADDR_W = 28,
    parameter int DATA_W = 256
);
    logic [ADDR_W-1:0] awaddr;
    logic [7:0]        awlen;
    logic              awvalid;
    logic              awready;
    logic [DATA_W-1:0] wdata;
    logic              wvalid;
    logic              wlast;
    logic              wready;
    logic              bvalid;
    logic [1:0]        bresp;
    logic              bready;

    modport master (
        output awaddr, awlen, awvalid,
        input  awready,
        output wdata, wvalid, wlast,
        input  wready,
        input  bvalid, bresp,
        output bready
    );

    modport slave (
        input  awaddr, awlen, awvalid,
        output awready,
        input  wdata, wvalid, wlast,
        output wready,
        output bvalid, bresp,
        input  bready
    );
endinterface

// File: rtl/wr_ddr_burst_arbiter.sv
// rtl/wr_ddr_burst_arbiter.sv - round-robin write-burst scheduler draining per-channel FIFOs into one AXI4 write master
//
// Purpose: picks a channel with a full burst buffered, issues one fixed-length INCR
// burst at that channel's current frame-buffer address, pops the FIFO beat by beat,
// then waits for the write response before arbitrating again.
// Ports:
//   rd_clk, rd_rst      : clock, asynchronous active-high reset
//   cfg_base            : per-channel frame base address (quasi-static)
//   frame_start         : per-channel pulse restarting the address at base
//   ch_burst_rdy        : per-channel "full burst buffered" level
//   fifo_rd_data/vld/en : FIFO read side, channel 0 in the LSBs
//   m                   : AXI4 write master (AW/W/B)
//   busy, cur_ch        : status (not idle, granted channel)
//   err_pulse           : one-cycle pulse on a non-OKAY write response

module wr_ddr_burst_arbiter #(
    parameter int CH_NUM       = 4,
    parameter int DATA_W       = 256,
    parameter int ADDR_W       = 28,
    parameter int BURST_LEN    = 16,
    parameter int FRAME_BURSTS = 8100
) (
    input  logic                       rd_clk,
    input  logic                       rd_rst,
    input  logic [CH_NUM*ADDR_W-1:0]   cfg_base,
    input  logic [CH_NUM-1:0]          frame_start,
    input  logic [CH_NUM-1:0]          ch_burst_rdy,
    input  logic [CH_NUM*DATA_W-1:0]   fifo_rd_data,
    input  logic [CH_NUM-1:0]          fifo_rd_vld,
    output logic [CH_NUM-1:0]          fifo_rd_en,
    wr_ddr_burst_arbiter_if.master     m,
    output logic                       busy,
    output logic [2:0]                 cur_ch,
    output logic                       err_pulse
);

    localparam int CH_IDX_W = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
    localparam int IDX_W    = $clog2(FRAME_BURSTS);

    localparam logic [ADDR_W-1:0] BURST_BYTES = ADDR_W'(BURST_LEN * DATA_W / 8);
    localparam logic [IDX_W-1:0]  LAST_IDX    = IDX_W'(FRAME_BURSTS - 1);
    localparam logic [7:0]        LAST_BEAT   = 8'(BURST_LEN - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_AW   = 2'd1;
    localparam logic [1:0] ST_W    = 2'd2;
    localparam logic [1:0] ST_B    = 2'd3;

    logic [1:0]          state;
    logic [CH_IDX_W-1:0] cur_idx;
    logic [CH_IDX_W-1:0] last_grant;
    logic [ADDR_W-1:0]   awaddr_q;
    logic [7:0]          beat_cnt;

    logic [ADDR_W-1:0]   off  [CH_NUM];
    logic [IDX_W-1:0]    bidx [CH_NUM];
    logic [CH_NUM-1:0]   pending;

    logic                gnt_found;
    logic [CH_IDX_W-1:0] gnt_idx;
    logic [CH_NUM-1:0]   own;
    logic                aw_hs;
    logic                w_hs;
    logic                b_done;

    // Round-robin search starting one past the last granted channel.
    always_comb begin
        logic [CH_IDX_W-1:0] cand;
        cand      = '0;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int k = 1; k <= CH_NUM; k++) begin
            cand = CH_IDX_W'((int'(last_grant) + k) % CH_NUM);
            if (!gnt_found && ch_burst_rdy[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    // own[i]: channel i holds the bus, so a frame_start on it must be deferred.
    always_comb begin
        own = '0;
        for (int i = 0; i < CH_NUM; i++) begin
            own[i] = busy && (cur_idx == CH_IDX_W'(i));
        end
    end

    assign busy      = (state != ST_IDLE);
    assign cur_ch    = 3'(cur_idx);

    assign m.awvalid = (state == ST_AW);
    assign m.awaddr  = awaddr_q;
    assign m.awlen   = LAST_BEAT;
    assign m.wvalid  = (state == ST_W) && fifo_rd_vld[cur_idx];
    assign m.wdata   = fifo_rd_data[cur_idx*DATA_W +: DATA_W];
    assign m.wlast   = (state == ST_W) && (beat_cnt == LAST_BEAT);
    assign m.bready  = (state == ST_B);

    assign aw_hs     = (state == ST_AW) && m.awready;
    assign w_hs      = m.wvalid && m.wready;
    assign b_done    = (state == ST_B) && m.bvalid;
    assign err_pulse = b_done && (m.bresp != 2'b00);

    always_comb begin
        fifo_rd_en = '0;
        if (w_hs) begin
            fifo_rd_en[cur_idx] = 1'b1;
        end
    end

    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            state      <= ST_IDLE;
            cur_idx    <= '0;
            last_grant <= CH_IDX_W'(CH_NUM - 1);
            awaddr_q   <= '0;
            beat_cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (gnt_found) begin
                        cur_idx <= gnt_idx;
                        // A frame_start arriving with the grant clears the offset
                        // this same cycle, so the address must already use zero.
                        awaddr_q <= cfg_base[gnt_idx*ADDR_W +: ADDR_W]
                                  + (frame_start[gnt_idx] ? '0 : off[gnt_idx]);
                        state    <= ST_AW;
                    end
                end
                ST_AW: begin
                    if (m.awready) begin
                        beat_cnt <= '0;
                        state    <= ST_W;
                    end
                end
                ST_W: begin
                    if (w_hs) begin
                        if (m.wlast) begin
                            state <= ST_B;
                        end else begin
                            beat_cnt <= beat_cnt + 8'd1;
                        end
                    end
                end
                default: begin
                    if (m.bvalid) begin
                        last_grant <= cur_idx;
                        state      <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    // Per-channel frame position. The owning channel's restart is held in
    // pending until the response returns, which also discards the increment
    // made at its AW handshake.
    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            for (int i = 0; i < CH_NUM; i++) begin
                off[i]  <= '0;
                bidx[i] <= '0;
            end
            pending <= '0;
        end else begin
            for (int i = 0; i < CH_NUM; i++) begin
                if (frame_start[i] && !own[i]) begin
                    off[i]  <= '0;
                    bidx[i] <= '0;
                end else if (own[i]) begin
                    if (aw_hs) begin
                        if (bidx[i] == LAST_IDX) begin
                            off[i]  <= '0;
                            bidx[i] <= '0;
                        end else begin
                            off[i]  <= off[i] + BURST_BYTES;
                            bidx[i] <= bidx[i] + IDX_W'(1);
                        end
                    end
                    if (frame_start[i]) begin
                        pending[i] <= 1'b1;
                    end
                    if (b_done && (pending[i] || frame_start[i])) begin
                        off[i]     <= '0;
                        bidx[i]    <= '0;
                        pending[i] <= 1'b0;
                    end
                end
            end
        end
    end

endmodule

// File: doc/wr_ddr_burst_arbiter.md
# wr_ddr_burst_arbiter

Round-robin write-burst scheduler that drains up to CH_NUM `wr_ddr_fifo` prefetch FIFOs, one per video channel, into a single AXI4 write master toward the DDR controller. It sits in the read-clock domain of the FIFOs. It picks a channel that has a full burst buffered, issues one fixed-length INCR burst to that channel's frame buffer, and pops the FIFO beat by beat. It then waits for the write response before arbitrating again.

## Interface
Parameters:
- CH_NUM, 4: number of channels (2..8).
- DATA_W, 256: FIFO read width and AXI data width; must be a multiple of 8.
- ADDR_W, 28: byte address width.
- BURST_LEN, 16: beats per burst (1..256).
- FRAME_BURSTS, 8100: bursts per frame per channel; must be ≥2.

Ports:
- rd_clk  in  1  clock.
- rd_rst  in  1  reset, asynchronous, active-high.
- cfg_base  in  CH_NUM*ADDR_W  per-channel frame base address; must be quasi-static.
- frame_start  in  CH_NUM  per-channel pulse that restarts the address at base.
- ch_burst_rdy  in  CH_NUM  level: channel FIFO holds ≥BURST_LEN beats; already synchronised into rd_clk.
- fifo_rd_data  in  CH_NUM*DATA_W  FIFO rd_data, channel 0 in the LSBs.
- fifo_rd_vld  in  CH_NUM  FIFO rd_vld.
- fifo_rd_en  out  CH_NUM  FIFO rd_en (pop).
- m_awaddr  out  ADDR_W;  m_awlen  out  8;  m_awvalid  out  1;  m_awready  in  1.
- m_wdata  out  DATA_W;  m_wvalid  out  1;  m_wlast  out  1;  m_wready  in  1.
- m_bvalid  in  1;  m_bresp  in  2;  m_bready  out  1.
- busy  out  1  state ≠ IDLE.
- cur_ch  out  3  channel currently granted.
- err_pulse  out  1  one-cycle pulse when a burst completes with bresp ≠ 0.

## Operation
- FSM states: IDLE, AW, W, B.
- **IDLE**
  - If any ch_burst_rdy bit is set, grant the first set bit searching from last_grant+1 upward, modulo CH_NUM.
  - Register the grant into cur_ch and go to AW on the next cycle.
  - After reset, last_grant = CH_NUM-1, so channel 0 has first priority.
- **AW**
  - m_awvalid=1, m_awaddr = base[cur_ch] + off[cur_ch], m_awlen = BURST_LEN-1.
  - On awvalid&awready:
    - off[cur_ch] += BURST_LEN*DATA_W/8.
    - burst_idx[cur_ch]++; if burst_idx was FRAME_BURSTS-1, clear both off and burst_idx.
    - Go to W.
- **W**
  - m_wvalid = fifo_rd_vld[cur_ch]; m_wdata = the selected slice.
  - fifo_rd_en[cur_ch] = m_wvalid & m_wready. All other fifo_rd_en bits are 0 in every state.
  - A beat counter counts handshakes. m_wlast = 1 when the counter = BURST_LEN-1.
  - The handshake carrying wlast moves the FSM to B.
  - A gap in fifo_rd_vld stalls wvalid. There is no timeout.
- **B**
  - m_bready=1.
  - On bvalid: err_pulse = (bresp≠0) for one cycle, last_grant = cur_ch, go to IDLE.
- **frame_start[i]**
  - When channel i is not the active channel (or busy=0): clear off[i] and burst_idx[i] in the same cycle.
  - When i = cur_ch and busy=1: latch a pending flag and apply the clear when leaving B. The in-flight burst keeps its address.
- Simultaneous frame_start[i] and an AW handshake on channel i outside IDLE: the pending flag takes effect, and the increment is discarded at B exit.
- ch_burst_rdy is sampled only in IDLE. Deassertion during a burst has no effect.

## Timing
- Reset values:
  - state=IDLE; cur_ch=0; last_grant=CH_NUM-1.
  - All off, burst_idx and pending flags = 0.
  - m_awvalid=m_wvalid=m_wlast=m_bready=0; fifo_rd_en=0; busy=0; err_pulse=0.
  - m_awaddr=0; m_awlen=BURST_LEN-1.
- Reset asserted mid-burst returns the block to IDLE immediately. The DDR side is reset with it.
- ch_burst_rdy seen in IDLE → m_awvalid high 1 cycle later.
- AW handshake → W state next cycle. The first beat can complete in that cycle.
- With continuous vld/ready: BURST_LEN cycles in W, then B. The minimum gap from bvalid to the next awvalid is 2 cycles (IDLE, AW).
- m_awvalid, m_awaddr and m_awlen hold stable until awready. m_wdata is combinational from the FIFO output register.

## Test plan
- Single channel, ch_burst_rdy[0]=1, base=0x100000, BURST_LEN=16, DATA_W=256, always-ready slave → awaddr 0x100000, then 0x100200; exactly 16 pops per burst; wlast on beat 15.
- All four channels ready continuously → grant order 0,1,2,3,0…; no channel is granted twice in a row while others request.
- FRAME_BURSTS=2, channel 1 → addresses base, base+0x200, base, base+0x200 (wrap).
- fifo_rd_vld toggles 1/0 and m_wready is randomised during W → no pop without the handshake, beat order preserved, wlast only on beat 15.
- frame_start[2] pulsed during channel 2's W state → current burst completes at its address; the next channel-2 burst starts at base[2].
- bresp=2'b10 on a response → err_pulse high for 1 cycle, FSM returns to IDLE, the next arbitration proceeds normally.
